mem_arbiter: RTL

Shares the core's single external memory bus between the instruction-cache refill port and the data-cache port. A small FSM selects one requester, then drives either a fixed-length burst of read beats or a single read/write onto the bus. Read data, beat-valid, done and error indications go back to the owning cache. It sits between the core's `ADR_SI`/`IC_INST_SI` and `MCACHE_*` cache controllers and the system RAM/bus interface.

---
 rtl/mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single external memory bus between the instruction-cache refill
// port (IC_*) and the data-cache port (DC_*). A three-state FSM picks one
// requester, then issues either a BURST_LEN-beat incrementing read burst or a
// single read/write beat. Read data, beat-valid, done and error indications
// are returned, registered, to the owning port.
//
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN  defined   -> one-bit last-owner pointer; on a
//                                        conflict the port not served last
//                                        wins (data port wins the first one).
//                           undefined -> fixed priority, data port wins.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   IC_REQ_SI/IC_ADR_SI   instruction refill request and address
//   IC_GNT_SA             one-cycle grant pulse for the instruction port
//   IC_DATA_SA/IC_DVALID_SA/IC_DONE_SA  registered read data, valid, done
//   DC_REQ_SM/DC_ADR_SM/DC_WE_SM/DC_WDATA_SM/DC_BYTSEL_SM/DC_BURST_SM
//                         data-port request, address, write controls, burst
//   DC_GNT_SA/DC_RDATA_SA/DC_DVALID_SA/DC_DONE_SA  data-port responses
//   ERR_SA                qualifies a done pulse: 1 = bus error termination
//   BUS_REQ_SA/BUS_ADR_SA/BUS_WE_SA/BUS_WDATA_SA/BUS_BYTSEL_SA  beat request
//   BUS_ACK_SX/BUS_RDATA_SX/BUS_ERR_SX  beat acknowledge, read data, error
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int BURST_LEN = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        IC_REQ_SI,
    input  logic [31:0] IC_ADR_SI,
    output logic        IC_GNT_SA,
    output logic [31:0] IC_DATA_SA,
    output logic        IC_DVALID_SA,
    output logic        IC_DONE_SA,

    input  logic        DC_REQ_SM,
    input  logic [31:0] DC_ADR_SM,
    input  logic        DC_WE_SM,
    input  logic [31:0] DC_WDATA_SM,
    input  logic [3:0]  DC_BYTSEL_SM,
    input  logic        DC_BURST_SM,
    output logic        DC_GNT_SA,
    output logic [31:0] DC_RDATA_SA,
    output logic        DC_DVALID_SA,
    output logic        DC_DONE_SA,

    output logic        ERR_SA,

    output logic        BUS_REQ_SA,
    output logic [31:0] BUS_ADR_SA,
    output logic        BUS_WE_SA,
    output logic [31:0] BUS_WDATA_SA,
    output logic [3:0]  BUS_BYTSEL_SA,
    input  logic        BUS_ACK_SX,
    input  logic [31:0] BUS_RDATA_SX,
    input  logic        BUS_ERR_SX
);

    localparam int              CW        = $clog2(BURST_LEN);
    // Clears the in-burst word index and the byte offset of a burst base.
    localparam logic [31:0]     BASE_MASK = 32'(BURST_LEN * 4 - 1);
    localparam logic [CW-1:0]   LAST_BEAT = CW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        XFER_I = 2'd1,
        XFER_D = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  beat_q, beat_d;

    logic           ic_gnt_q, ic_gnt_d;
    logic [31:0]    ic_data_q, ic_data_d;
    logic           ic_dvalid_q, ic_dvalid_d;
    logic           ic_done_q, ic_done_d;

    logic           dc_gnt_q, dc_gnt_d;
    logic [31:0]    dc_rdata_q, dc_rdata_d;
    logic           dc_dvalid_q, dc_dvalid_d;
    logic           dc_done_q, dc_done_d;

    logic           err_q, err_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic           d_wins_tie;
    logic           grant_i;
    logic           grant_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 1 = data port owned the bus last. Resets to the instruction port so
    // the data port takes the first conflict.
    logic           last_d_q, last_d_d;
    assign d_wins_tie = ~last_d_q;
`else
    assign d_wins_tie = 1'b1;
`endif

    assign grant_d = DC_REQ_SM & (~IC_REQ_SI | d_wins_tie);
    assign grant_i = IC_REQ_SI & ~grant_d;

    // ------------------------------------------------------------------
    // Beat bookkeeping
    // ------------------------------------------------------------------
    logic           dc_multi;
    logic           last_beat;
    logic [31:0]    beat_ofs;

    // Data-port bursts only apply to reads; a write is always one beat.
    assign dc_multi = DC_BURST_SM & ~DC_WE_SM;
    assign beat_ofs = {{(30 - CW){1'b0}}, beat_q, 2'b00};

    always_comb begin
        last_beat = 1'b1;
        case (state_q)
            XFER_I:  last_beat = (beat_q == LAST_BEAT);
            XFER_D:  last_beat = ~dc_multi | (beat_q == LAST_BEAT);
            default: last_beat = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus drive: purely a function of state, counter and owner inputs, so
    // everything drops to zero as soon as the FSM leaves a transfer state
    // (including the instant reset is applied).
    // ------------------------------------------------------------------
    always_comb begin
        BUS_REQ_SA    = 1'b0;
        BUS_ADR_SA    = 32'h0;
        BUS_WE_SA     = 1'b0;
        BUS_WDATA_SA  = 32'h0;
        BUS_BYTSEL_SA = 4'h0;
        case (state_q)
            XFER_I: begin
                BUS_REQ_SA    = 1'b1;
                BUS_ADR_SA    = (IC_ADR_SI & ~BASE_MASK) + beat_ofs;
                BUS_BYTSEL_SA = 4'hF;
            end
            XFER_D: begin
                BUS_REQ_SA    = 1'b1;
                BUS_WE_SA     = DC_WE_SM;
                BUS_ADR_SA    = dc_multi ? ((DC_ADR_SM & ~BASE_MASK) + beat_ofs)
                                         : DC_ADR_SM;
                BUS_WDATA_SA  = DC_WE_SM ? DC_WDATA_SM : 32'h0;
                BUS_BYTSEL_SA = DC_WE_SM ? DC_BYTSEL_SM : 4'hF;
            end
            default: begin
                BUS_REQ_SA    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        ic_gnt_d    = 1'b0;
        ic_data_d   = ic_data_q;
        ic_dvalid_d = 1'b0;
        ic_done_d   = 1'b0;
        dc_gnt_d    = 1'b0;
        dc_rdata_d  = dc_rdata_q;
        dc_dvalid_d = 1'b0;
        dc_done_d   = 1'b0;
        err_d       = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d_d    = last_d_q;
`endif

        case (state_q)
            IDLE: begin
                // Acks arriving here belong to nobody and are dropped.
                if (grant_d) begin
                    state_d  = XFER_D;
                    dc_gnt_d = 1'b1;
                    beat_d   = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_d_d = 1'b1;
`endif
                end else if (grant_i) begin
                    state_d  = XFER_I;
                    ic_gnt_d = 1'b1;
                    beat_d   = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_d_d = 1'b0;
`endif
                end
            end

            XFER_I: begin
                if (BUS_ACK_SX) begin
                    ic_data_d   = BUS_RDATA_SX;
                    ic_dvalid_d = 1'b1;
                    beat_d      = beat_q + CW'(1);
                    if (last_beat || BUS_ERR_SX) begin
                        state_d   = IDLE;
                        ic_done_d = 1'b1;
                        err_d     = BUS_ERR_SX;
                    end
                end
            end

            XFER_D: begin
                if (BUS_ACK_SX) begin
                    // Write acks carry no data back to the cache.
                    if (!DC_WE_SM) begin
                        dc_rdata_d  = BUS_RDATA_SX;
                        dc_dvalid_d = 1'b1;
                    end
                    beat_d = beat_q + CW'(1);
                    if (last_beat || BUS_ERR_SX) begin
                        state_d   = IDLE;
                        dc_done_d = 1'b1;
                        err_d     = BUS_ERR_SX;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            ic_gnt_q    <= 1'b0;
            ic_data_q   <= 32'h0;
            ic_dvalid_q <= 1'b0;
            ic_done_q   <= 1'b0;
            dc_gnt_q    <= 1'b0;
            dc_rdata_q  <= 32'h0;
            dc_dvalid_q <= 1'b0;
            dc_done_q   <= 1'b0;
            err_q       <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_d_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            ic_gnt_q    <= ic_gnt_d;
            ic_data_q   <= ic_data_d;
            ic_dvalid_q <= ic_dvalid_d;
            ic_done_q   <= ic_done_d;
            dc_gnt_q    <= dc_gnt_d;
            dc_rdata_q  <= dc_rdata_d;
            dc_dvalid_q <= dc_dvalid_d;
            dc_done_q   <= dc_done_d;
            err_q       <= err_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_d_q    <= last_d_d;
`endif
        end
    end

    assign IC_GNT_SA    = ic_gnt_q;
    assign IC_DATA_SA   = ic_data_q;
    assign IC_DVALID_SA = ic_dvalid_q;
    assign IC_DONE_SA   = ic_done_q;
    assign DC_GNT_SA    = dc_gnt_q;
    assign DC_RDATA_SA  = dc_rdata_q;
    assign DC_DVALID_SA = dc_dvalid_q;
    assign DC_DONE_SA   = dc_done_q;
    assign ERR_SA       = err_q;

endmodule
